// File: rtl/alu_mul_seq.sv
// Sequential 8x8 unsigned shift-and-add multiplier that borrows an external
// combinational ALU for its additions; shifting and counting stay local.
module alu_mul_seq #(
   parameter int         WIDTH     = 8,
   parameter logic [3:0] OP_ADD    = 4'b0000,
   parameter int         CARRY_BIT = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product,
   output logic [WIDTH-1:0]     alu_a,
   output logic [WIDTH-1:0]     alu_b,
   output logic [3:0]           alu_op,
   input  logic [WIDTH-1:0]     alu_res,
   input  logic [WIDTH-1:0]     alu_flag,
   output logic [1:0]           state_dbg
);

   // Handshake: start is a request sampled only in IDLE (accepted on that
   // edge, never queued); done is a one-cycle pulse marking product valid.

   typedef enum logic [1:0] {S_IDLE, S_ADD, S_SHIFT, S_DONE} state_t;

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] m_reg;
   logic [WIDTH-1:0] p_reg;
   logic [WIDTH-1:0] q_reg;
   logic             c_reg;
   logic [CW-1:0]    cnt;

   logic             carry_in;
   logic             unused_flag;

   assign carry_in    = alu_flag[CARRY_BIT];
   assign unused_flag = ^alu_flag;
   assign state_dbg   = state;

   // ALU drive depends only on state and local registers, never on start.
   always_comb begin
      alu_op = OP_ADD;
      alu_a  = '0;
      alu_b  = '0;
      if (state == S_ADD) begin
         alu_a = p_reg;
         alu_b = q_reg[0] ? m_reg : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         m_reg   <= '0;
         p_reg   <= '0;
         q_reg   <= '0;
         c_reg   <= 1'b0;
         cnt     <= '0;
         product <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  m_reg <= op_a;
                  q_reg <= op_b;
                  p_reg <= '0;
                  c_reg <= 1'b0;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= S_ADD;
               end
            end
            S_ADD: begin
               p_reg <= alu_res;
               c_reg <= carry_in;
               state <= S_SHIFT;
            end
            S_SHIFT: begin
               // {C,P,Q} shifts right as one 2*WIDTH+1 bit register.
               p_reg <= {c_reg, p_reg[WIDTH-1:1]};
               q_reg <= {p_reg[0], q_reg[WIDTH-1:1]};
               c_reg <= 1'b0;
               if (cnt == LAST) begin
                  product <= {c_reg, p_reg[WIDTH-1:1], p_reg[0], q_reg[WIDTH-1:1]};
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  cnt   <= cnt + 1'b1;
                  state <= S_ADD;
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Self-checking bench for alu_mul_seq: an arithmetic ALU model, directed
// corner cases, back-to-back start, mid-operation reset and operand sweeps.
module tb_alu_mul_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  op_a;
   logic [7:0]  op_b;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [3:0]  alu_op;
   logic [7:0]  alu_res;
   logic [7:0]  alu_flag;
   logic [1:0]  state_dbg;

   int errors;
   int checks;
   int carry_cnt;

   logic [15:0] exp_q[$];

   alu_mul_seq #(.WIDTH(8), .OP_ADD(4'b0000), .CARRY_BIT(0)) dut (
      .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b),
      .busy(busy), .done(done), .product(product),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_res(alu_res), .alu_flag(alu_flag), .state_dbg(state_dbg)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU: ADD gives the 9-bit sum split into result and carry.
   always_comb begin
      int sum;
      sum      = int'(alu_a) + int'(alu_b);
      alu_res  = (alu_op == 4'b0000) ? sum[7:0] : 8'hA5;
      alu_flag = {7'b0, (alu_op == 4'b0000) ? sum[8] : 1'b0};
   end

   // Driver + per-cycle checker for one multiplication from an idle DUT.
   task automatic run_op(input int a, input int b);
      int done_k;
      int busy_n;
      int exp_a;
      int exp_b;
      int i;
      logic [15:0] exp_p;
      exp_p  = 16'(a * b);
      done_k = 0;
      busy_n = 0;
      @(negedge clk);
      start = 1'b1;
      op_a  = 8'(a);
      op_b  = 8'(b);
      @(negedge clk);
      start = 1'b0;
      op_a  = 8'($urandom_range(0, 255));
      op_b  = 8'($urandom_range(0, 255));
      for (int k = 1; k <= 40; k++) begin
         if (k > 1) @(negedge clk);
         if (busy) busy_n++;
         exp_a = 0;
         exp_b = 0;
         if ((k % 2) == 1 && k <= 15) begin
            i     = (k - 1) / 2;
            exp_a = (a * (b % (1 << i))) >> i;
            exp_b = ((b >> i) & 1) ? a : 0;
         end
         if (int'(alu_a) + int'(alu_b) > 255) carry_cnt++;
         checks++;
         if (alu_a !== 8'(exp_a) || alu_b !== 8'(exp_b) || alu_op !== 4'b0000) begin
            errors++;
            $display("FAIL alu_drive %0d*%0d cycle %0d: got a=%h b=%h op=%h want a=%h b=%h op=0",
                     a, b, k, alu_a, alu_b, alu_op, 8'(exp_a), 8'(exp_b));
         end
         if (done) begin
            done_k = k;
            break;
         end
      end
      checks++;
      if (done_k != 17) begin
         errors++;
         $display("FAIL done_latency %0d*%0d: got cycle %0d want 17 (0 = timeout)", a, b, done_k);
      end
      checks++;
      if (busy_n != 16) begin
         errors++;
         $display("FAIL busy_cycles %0d*%0d: got %0d want 16", a, b, busy_n);
      end
      checks++;
      if (product !== exp_p) begin
         errors++;
         $display("FAIL product %0d*%0d: got %h want %h", a, b, product, exp_p);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || product !== exp_p) begin
         errors++;
         $display("FAIL after_done %0d*%0d: got done=%b busy=%b product=%h want 0 0 %h",
                  a, b, done, busy, product, exp_p);
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b0;
      op_a  = 8'h00;
      op_b  = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b done=%b product=%h want 0 0 0000", busy, done, product);
      end
      checks++;
      if (alu_a !== 8'h00 || alu_b !== 8'h00 || alu_op !== 4'h0) begin
         errors++;
         $display("FAIL reset_alu: got a=%h b=%h op=%h want 00 00 0", alu_a, alu_b, alu_op);
      end
   endtask

   task automatic test_directed();
      run_op(8'h0D, 8'h0B);
      carry_cnt = 0;
      run_op(8'hFF, 8'hFF);
      checks++;
      if (carry_cnt == 0) begin
         errors++;
         $display("FAIL carry_seen 255*255: got %0d carry adds want >0", carry_cnt);
      end
      run_op(8'h00, 8'hA5);
      run_op(8'h80, 8'h02);
   endtask

   task automatic test_back_to_back();
      int next_accept;
      int last_done;
      int done_cnt;
      logic [15:0] got_exp;
      next_accept = 0;
      last_done   = -1;
      done_cnt    = 0;
      exp_q.delete();
      for (int m = 0; m < 96; m++) begin
         @(negedge clk);
         if (m > 0 && done) begin
            done_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra_done at cycle %0d: got done=1 want no pending result", m);
            end else begin
               got_exp = exp_q.pop_front();
               if (product !== got_exp) begin
                  errors++;
                  $display("FAIL b2b_product cycle %0d: got %h want %h", m, product, got_exp);
               end
            end
            if (last_done >= 0) begin
               checks++;
               if (m - last_done != 18) begin
                  errors++;
                  $display("FAIL b2b_spacing: got %0d cycles want 18", m - last_done);
               end
            end
            last_done = m;
         end
         if (m < 72) begin
            start = 1'b1;
            op_a  = 8'($urandom_range(0, 255));
            op_b  = 8'($urandom_range(0, 255));
            if (m == next_accept) begin
               exp_q.push_back(16'(int'(op_a) * int'(op_b)));
               next_accept = m + 18;
            end
         end else begin
            start = 1'b0;
         end
      end
      checks++;
      if (done_cnt != 4 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL b2b_count: got %0d dones, %0d pending want 4, 0", done_cnt, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      int stray;
      stray = 0;
      @(negedge clk);
      start = 1'b1;
      op_a  = 8'h37;
      op_b  = 8'hA9;
      for (int k = 1; k <= 7; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 7) rst = 1'b1;
      end
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000) begin
         errors++;
         $display("FAIL reset_mid: got busy=%b done=%b product=%h want 0 0 0000", busy, done, product);
      end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done || busy) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("FAIL reset_abort: got %0d active cycles after reset want 0", stray);
      end
      run_op(8'h03, 8'h05);
   endtask

   task automatic test_sweep();
      for (int a = 0; a <= 255; a += 10) begin
         for (int b = 0; b <= 255; b += 5) begin
            run_op(a, b);
         end
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 40; n++) begin
         run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      carry_cnt = 0;
      rst       = 1'b1;
      start     = 1'b0;
      op_a      = 8'h00;
      op_b      = 8'h00;
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_mid();
      test_random();
      test_sweep();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
